uart_block_assembler: RTL and testbench
=======================================

# uart_block_assembler

Sits directly downstream of the UART `receiver` and upstream of the AES-128 core. Consumes the receiver's one-cycle byte strobes and packs 32 consecutive bytes into a 128-bit key followed by a 128-bit plaintext block. Presents the pair to the AES core with a valid/ready handshake. Discards partial frames after an inter-byte timeout so a host glitch cannot permanently misalign the stream.

## Interface

Parameters:
- `TIMEOUT_CLKS`, default 86800: idle clocks allowed between bytes of a partial frame. The default is 10 byte times at 868 clocks/bit.
- `TMR_W`, default 17: width of the timeout counter. Must satisfy 2^TMR_W > TIMEOUT_CLKS.

Ports:
- `CLK`  in  1  system clock (100 MHz); all logic rises on it.
- `RST_in`  in  1  reset, synchronous, active-high.
- `Rx_DV_in`  in  1  byte strobe from `receiver.Rx_DV_out`; one cycle per byte.
- `Rx_Byte_in`  in  8  byte from `receiver.Rx_Byte_out`; valid only when `Rx_DV_in`=1.
- `Key_out`  out  128  assembled key; byte 0 of the frame is in [127:120].
- `Data_out`  out  128  assembled plaintext; frame byte 16 is in [127:120].
- `Valid_out`  out  1  key/data pair held stable and ready for the AES core.
- `Ready_in`  in  1  AES core accepts the pair on a cycle where `Valid_out`=1.
- `Count_out`  out  6  number of bytes accepted into the current frame, 0–32 (debug/LED).
- `Overflow_out`  out  1  one-cycle pulse: a byte was dropped while holding.
- `Timeout_out`  out  1  one-cycle pulse: a partial frame was discarded.

## Operation

- The FSM has three states: `COLLECT_KEY`, `COLLECT_DATA` and `HOLD`. Reset enters `COLLECT_KEY`.
- **`COLLECT_KEY`**
  - Each `Rx_DV_in` writes `Rx_Byte_in` into `Key_out` at slot `Count_out` (slot n occupies bits [127-8n -: 8]).
  - Each such byte increments `Count_out`.
  - After the 16th byte, go to `COLLECT_DATA`.
- **`COLLECT_DATA`**
  - Same as `COLLECT_KEY`, but writes into `Data_out` at slot `Count_out`-16.
  - After the 32nd byte, go to `HOLD` with `Count_out`=32.
- **`HOLD`**
  - `Valid_out`=1, and `Key_out`/`Data_out` stay frozen.
  - On `Valid_out`&`Ready_in`: go to `COLLECT_KEY`, clear `Count_out` to 0 and deassert `Valid_out`.
  - `Rx_DV_in` without a handshake in the same cycle: the byte is dropped and `Overflow_out` pulses.
  - `Rx_DV_in` in the same cycle as the handshake: the byte is accepted as key byte 0 of the next frame, and `Count_out` becomes 1.
- **Timeout**
  - The timer runs only in the collect states with `Count_out`≠0.
  - The timer is cleared by every accepted byte.
  - When it reaches `TIMEOUT_CLKS`-1 without a byte:
    - `Count_out` becomes 0 and the state returns to `COLLECT_KEY`.
    - `Timeout_out` pulses.
    - Stale bytes in `Key_out`/`Data_out` are not cleared; they are overwritten by the next frame.
  - A byte arriving in the expiry cycle takes priority: it is accepted, the timer clears, and there is no timeout.
- Output contents are not cleared between frames. `Key_out`/`Data_out` are meaningful only while `Valid_out`=1.

## Timing

- Reset values:
  - `Key_out`=0, `Data_out`=0, `Count_out`=0.
  - `Valid_out`, `Overflow_out` and `Timeout_out` all 0.
  - Timer=0, state `COLLECT_KEY`.
- `RST_in` mid-frame or during `HOLD` discards everything on that edge. A byte strobe in the reset cycle is ignored.
- Latency:
  - The byte is registered on the `CLK` edge where `Rx_DV_in`=1.
  - `Count_out` updates on that same edge.
  - `Valid_out` rises on the edge that accepts byte 32, so it is visible the cycle after that strobe.
- Handshake:
  - `Valid_out` falls on the edge where `Valid_out`&`Ready_in`=1.
  - Minimum HOLD duration is 1 cycle (when `Ready_in` is tied high).
  - `Ready_in` while `Valid_out`=0 is ignored.
- Throughput: the block accepts one byte per cycle if strobed back-to-back, so there is no minimum spacing requirement.
- `Overflow_out` and `Timeout_out` are registered, one cycle wide, and asserted the cycle after the causing edge.
- Timer width is `TMR_W`. It saturates and never wraps, because expiry resets it.

## Test plan

- **FIPS-197 vector.** Strobe bytes 00,01,…,0f then 00,11,22,…,ff with 10-cycle gaps, and hold `Ready_in`=0.
  - Required: `Key_out`=000102030405060708090a0b0c0d0e0f and `Data_out`=00112233445566778899aabbccddeeff.
  - Required: `Valid_out`=1 the cycle after byte 32, with `Count_out`=32.
- **Handshake.** From HOLD, pulse `Ready_in` for 1 cycle.
  - Required: `Valid_out`=0 and `Count_out`=0 next cycle; outputs stable throughout HOLD.
- **Overflow.** In HOLD with `Ready_in`=0, strobe byte 0xAA.
  - Required: one `Overflow_out` pulse; `Key_out`/`Data_out`/`Count_out` unchanged.
- **Simultaneous event.** Strobe 0x5A on the same cycle as the handshake.
  - Required: `Count_out`=1 and `Key_out`[127:120]=5A.
- **Timeout.** Send 5 bytes, then idle `TIMEOUT_CLKS` cycles.
  - Required: `Timeout_out` pulses once and `Count_out`=0.
  - Then send the full FIPS vector; it must assemble correctly.
  - Variant: a byte landing on the expiry cycle gives `Count_out`=6 and no pulse.
- **Reset mid-frame.** Assert `RST_in` for 1 cycle after 20 bytes.
  - Required: all outputs return to reset values.
  - The next 32 bytes then assemble correctly.

Source files
------------

// File: rtl/uart_block_assembler.sv
// uart_block_assembler
// Packs 32 consecutive UART bytes into a 128-bit AES key followed by a
// 128-bit plaintext block, then offers the pair to the AES core with a
// valid/ready handshake. Partial frames are dropped after an inter-byte
// timeout so a glitching host cannot leave the stream misaligned forever.

module uart_block_assembler #(
  parameter int TIMEOUT_CLKS = 86800,
  parameter int TMR_W        = 17
) (
  input  logic         CLK,
  input  logic         RST_in,
  input  logic         Rx_DV_in,
  input  logic [7:0]   Rx_Byte_in,
  output logic [127:0] Key_out,
  output logic [127:0] Data_out,
  output logic         Valid_out,
  input  logic         Ready_in,
  output logic [5:0]   Count_out,
  output logic         Overflow_out,
  output logic         Timeout_out
);

  typedef enum logic [1:0] {
    COLLECT_KEY  = 2'd0,
    COLLECT_DATA = 2'd1,
    HOLD         = 2'd2
  } state_t;

  // Timer value on which a silent partial frame is abandoned.
  localparam logic [TMR_W-1:0] LP_TMR_LAST = TMR_W'(TIMEOUT_CLKS - 1);

  state_t         r_state;
  state_t         w_nextState;
  logic [5:0]     r_count;
  logic [127:0]   r_key;
  logic [127:0]   r_data;
  logic [TMR_W-1:0] r_timer;
  logic           r_overflow;
  logic           r_timeout;

  logic           w_valid;
  logic           w_collecting;
  logic           w_handshake;
  logic           w_accept;
  logic           w_expire;
  logic           w_dropped;
  logic           w_wrKey;
  logic           w_wrData;
  logic [3:0]     w_slot;

  // State register: reset always lands in key collection.
  always_ff @(posedge CLK) begin
    if (RST_in) begin
      r_state <= COLLECT_KEY;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: an arriving byte always wins over a timeout expiry.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      COLLECT_KEY: begin
        if (Rx_DV_in && (r_count == 6'd15)) begin
          w_nextState = COLLECT_DATA;
        end else if (w_expire) begin
          w_nextState = COLLECT_KEY;
        end
      end
      COLLECT_DATA: begin
        if (Rx_DV_in && (r_count == 6'd31)) begin
          w_nextState = HOLD;
        end else if (w_expire) begin
          w_nextState = COLLECT_KEY;
        end
      end
      HOLD: begin
        if (Ready_in) begin
          w_nextState = COLLECT_KEY;
        end
      end
      default: w_nextState = COLLECT_KEY;
    endcase
  end

  // Output/control decode derived from the current state and inputs.
  always_comb begin
    w_valid      = (r_state == HOLD);
    w_collecting = (r_state == COLLECT_KEY) || (r_state == COLLECT_DATA);
    w_handshake  = w_valid && Ready_in;
    w_accept     = Rx_DV_in && (w_collecting || w_handshake);
    w_dropped    = w_valid && Rx_DV_in && !Ready_in;
    w_expire     = w_collecting && (r_count != 6'd0) && !Rx_DV_in &&
                   (r_timer == LP_TMR_LAST);
    // A byte taken during the handshake is byte 0 of the next key.
    w_slot       = w_valid ? 4'd0 : r_count[3:0];
    w_wrKey      = w_accept && (r_state != COLLECT_DATA);
    w_wrData     = w_accept && (r_state == COLLECT_DATA);
  end

  // Byte counter: advances per accepted byte, cleared by handshake or expiry.
  always_ff @(posedge CLK) begin
    if (RST_in) begin
      r_count <= 6'd0;
    end else if (w_handshake) begin
      r_count <= Rx_DV_in ? 6'd1 : 6'd0;
    end else if (w_collecting && Rx_DV_in) begin
      r_count <= r_count + 6'd1;
    end else if (w_expire) begin
      r_count <= 6'd0;
    end
  end

  // Key and data shift-free slot writes; contents persist until overwritten.
  always_ff @(posedge CLK) begin
    if (RST_in) begin
      r_key  <= '0;
      r_data <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (w_wrKey && (w_slot == 4'(i))) begin
          r_key[127-8*i -: 8] <= Rx_Byte_in;
        end
        if (w_wrData && (w_slot == 4'(i))) begin
          r_data[127-8*i -: 8] <= Rx_Byte_in;
        end
      end
    end
  end

  // Inter-byte timer: only runs mid-frame, cleared by bytes and by expiry.
  always_ff @(posedge CLK) begin
    if (RST_in) begin
      r_timer <= '0;
    end else if (w_accept || w_expire || !w_collecting || (r_count == 6'd0)) begin
      r_timer <= '0;
    end else if (r_timer != '1) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // One-cycle status pulses, registered so they follow the causing edge.
  always_ff @(posedge CLK) begin
    if (RST_in) begin
      r_overflow <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_overflow <= w_dropped;
      r_timeout  <= w_expire;
    end
  end

  assign Key_out      = r_key;
  assign Data_out     = r_data;
  assign Valid_out    = w_valid;
  assign Count_out    = r_count;
  assign Overflow_out = r_overflow;
  assign Timeout_out  = r_timeout;

endmodule

// File: tb/tb_uart_block_assembler.sv
// Directed testbench for uart_block_assembler, using a short timeout so
// the expiry boundary can be hit on an exact cycle.

module tb_uart_block_assembler;

  localparam int TIMEOUT = 20;
  localparam int TW      = 5;

  logic         clk;
  logic         rst;
  logic         rxDv;
  logic [7:0]   rxByte;
  logic [127:0] keyOut;
  logic [127:0] dataOut;
  logic         validOut;
  logic         readyIn;
  logic [5:0]   countOut;
  logic         overflowOut;
  logic         timeoutOut;

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0]   frame [32];
  logic [127:0] expKey;
  logic [127:0] expData;

  uart_block_assembler #(
    .TIMEOUT_CLKS (TIMEOUT),
    .TMR_W        (TW)
  ) dut (
    .CLK          (clk),
    .RST_in       (rst),
    .Rx_DV_in     (rxDv),
    .Rx_Byte_in   (rxByte),
    .Key_out      (keyOut),
    .Data_out     (dataOut),
    .Valid_out    (validOut),
    .Ready_in     (readyIn),
    .Count_out    (countOut),
    .Overflow_out (overflowOut),
    .Timeout_out  (timeoutOut)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe one byte for exactly one cycle.
  task automatic applyStimulus(input logic [7:0] b);
    rxDv   = 1'b1;
    rxByte = b;
    tick();
    rxDv   = 1'b0;
    rxByte = 8'h00;
  endtask

  // Send the 32-byte frame array, checking the count after each byte.
  task automatic sendFrame(input int gap);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(frame[i]);
      checkOutput("count_progress", 128'(countOut), 128'(i + 1));
      if (i != 31) repeat (gap) tick();
    end
  endtask

  // Expected key/data from the frame array: byte n sits at [127-8n -: 8].
  task automatic buildExpected();
    for (int i = 0; i < 16; i++) begin
      expKey[127-8*i -: 8]  = frame[i];
      expData[127-8*i -: 8] = frame[i+16];
    end
  endtask

  task automatic loadFips();
    for (int i = 0; i < 16; i++) begin
      frame[i]    = 8'(i);
      frame[i+16] = 8'(i * 17);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_key"},   keyOut,            128'h0);
    checkOutput({tag, "_data"},  dataOut,           128'h0);
    checkOutput({tag, "_count"}, 128'(countOut),    128'd0);
    checkOutput({tag, "_valid"}, 128'(validOut),    128'd0);
    checkOutput({tag, "_ovf"},   128'(overflowOut), 128'd0);
    checkOutput({tag, "_tmo"},   128'(timeoutOut),  128'd0);
  endtask

  initial begin
    rst     = 1'b1;
    rxDv    = 1'b0;
    rxByte  = 8'h00;
    readyIn = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checkReset("reset");

    // FIPS-197 key/plaintext with 10-cycle gaps, core not ready.
    loadFips();
    sendFrame(10);
    checkOutput("fips_valid", 128'(validOut), 128'd1);
    checkOutput("fips_count", 128'(countOut), 128'd32);
    checkOutput("fips_key",  keyOut,  128'h000102030405060708090a0b0c0d0e0f);
    checkOutput("fips_data", dataOut, 128'h00112233445566778899aabbccddeeff);

    // HOLD outlasts the timeout window without change.
    for (int c = 0; c < 30; c++) begin
      tick();
      checkOutput("hold_valid", 128'(validOut),   128'd1);
      checkOutput("hold_key",   keyOut, 128'h000102030405060708090a0b0c0d0e0f);
      checkOutput("hold_tmo",   128'(timeoutOut), 128'd0);
    end

    // Overflow: byte strobed in HOLD without ready is dropped.
    applyStimulus(8'hAA);
    checkOutput("ovf_pulse", 128'(overflowOut), 128'd1);
    checkOutput("ovf_key",   keyOut,  128'h000102030405060708090a0b0c0d0e0f);
    checkOutput("ovf_data",  dataOut, 128'h00112233445566778899aabbccddeeff);
    checkOutput("ovf_count", 128'(countOut), 128'd32);
    checkOutput("ovf_valid", 128'(validOut), 128'd1);
    tick();
    checkOutput("ovf_end", 128'(overflowOut), 128'd0);

    // Handshake: single-cycle ready.
    readyIn = 1'b1;
    tick();
    readyIn = 1'b0;
    checkOutput("hs_valid", 128'(validOut), 128'd0);
    checkOutput("hs_count", 128'(countOut), 128'd0);
    // Ready while not valid is ignored.
    readyIn = 1'b1;
    tick();
    readyIn = 1'b0;
    checkOutput("idle_ready_count", 128'(countOut), 128'd0);

    // Back-to-back frame with a distinct pattern.
    for (int i = 0; i < 32; i++) frame[i] = 8'(8'hF0 ^ (i * 7));
    buildExpected();
    sendFrame(0);
    checkOutput("b2b_valid", 128'(validOut), 128'd1);
    checkOutput("b2b_key",   keyOut,  expKey);
    checkOutput("b2b_data",  dataOut, expData);

    // Simultaneous byte and handshake.
    rxDv    = 1'b1;
    rxByte  = 8'h5A;
    readyIn = 1'b1;
    tick();
    rxDv    = 1'b0;
    readyIn = 1'b0;
    checkOutput("sim_count", 128'(countOut), 128'd1);
    checkOutput("sim_key0",  128'(keyOut[127:120]), 128'h5A);
    checkOutput("sim_valid", 128'(validOut), 128'd0);
    checkOutput("sim_ovf",   128'(overflowOut), 128'd0);

    // Timeout: bring the partial frame to 5 bytes then go idle.
    for (int i = 0; i < 4; i++) applyStimulus(8'(8'h10 + i));
    checkOutput("tmo_count5", 128'(countOut), 128'd5);
    repeat (TIMEOUT - 1) tick();
    checkOutput("tmo_before", 128'(timeoutOut), 128'd0);
    checkOutput("tmo_before_count", 128'(countOut), 128'd5);
    tick();
    checkOutput("tmo_pulse", 128'(timeoutOut), 128'd1);
    checkOutput("tmo_count0", 128'(countOut), 128'd0);
    tick();
    checkOutput("tmo_pulse_end", 128'(timeoutOut), 128'd0);

    // Full FIPS frame after a timeout assembles cleanly.
    loadFips();
    sendFrame(10);
    checkOutput("post_tmo_valid", 128'(validOut), 128'd1);
    checkOutput("post_tmo_key",  keyOut,  128'h000102030405060708090a0b0c0d0e0f);
    checkOutput("post_tmo_data", dataOut, 128'h00112233445566778899aabbccddeeff);
    readyIn = 1'b1;
    tick();
    readyIn = 1'b0;
    checkOutput("post_tmo_hs", 128'(validOut), 128'd0);

    // Byte on the expiry cycle wins over the timeout.
    for (int i = 0; i < 5; i++) frame[i] = 8'(8'h30 + i);
    for (int i = 0; i < 5; i++) applyStimulus(frame[i]);
    repeat (TIMEOUT - 1) tick();
    frame[5] = 8'h35;
    applyStimulus(frame[5]);
    checkOutput("expiry_byte_count", 128'(countOut), 128'd6);
    checkOutput("expiry_byte_tmo",   128'(timeoutOut), 128'd0);
    tick();
    checkOutput("expiry_byte_tmo2",  128'(timeoutOut), 128'd0);

    // Reset mid-frame after 20 bytes, with a strobe in the reset cycle.
    for (int i = 6; i < 20; i++) applyStimulus(8'(8'h40 + i));
    checkOutput("pre_rst_count", 128'(countOut), 128'd20);
    rst    = 1'b1;
    rxDv   = 1'b1;
    rxByte = 8'hC3;
    tick();
    rst    = 1'b0;
    rxDv   = 1'b0;
    checkReset("midrst");

    // Next 32 bytes assemble correctly.
    for (int i = 0; i < 32; i++) frame[i] = 8'(8'h81 + i * 3);
    buildExpected();
    sendFrame(3);
    checkOutput("post_rst_valid", 128'(validOut), 128'd1);
    checkOutput("post_rst_key",   keyOut,  expKey);
    checkOutput("post_rst_data",  dataOut, expData);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
